// File: rtl/csa_resolver.sv
// csa_resolver: sequential carry-save to binary resolver.
// Accepts one (sum, carry) redundant pair. Ripples carries with an
// XOR/AND iteration until the carry vector is empty. Returns the binary
// value over a valid/ready handshake.
module csa_resolver #(
   parameter int unsigned WIDTH = 4
) (
   input  logic                              clk,
   input  logic                              rst_n,
   input  logic                              in_valid,
   output logic                              in_ready,
   input  logic [WIDTH-1:0]                  sum_in,
   input  logic [WIDTH-1:0]                  cout_in,
   output logic                              out_valid,
   input  logic                              out_ready,
   output logic [WIDTH+1:0]                  result,
   output logic [$clog2(WIDTH+3)-1:0]        iters
);

   localparam int unsigned RW = WIDTH + 2;
   localparam int unsigned CW = $clog2(WIDTH + 3);
   localparam logic [CW-1:0] MAX_ITERS = CW'(WIDTH + 2);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   state_e        state_q, state_d;
   logic [RW-1:0] s_q, s_d;
   logic [RW-1:0] c_q, c_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [RW-1:0] result_q, result_d;
   logic [CW-1:0] iters_q, iters_d;
   logic          out_valid_q, out_valid_d;
   logic          in_ready_q, in_ready_d;

   // State and datapath registers; reset parks the FSM in IDLE and drops any in-flight pair
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         s_q         <= '0;
         c_q         <= '0;
         cnt_q       <= '0;
         result_q    <= '0;
         iters_q     <= '0;
         out_valid_q <= 1'b0;
         in_ready_q  <= 1'b1;
      end else begin
         state_q     <= state_d;
         s_q         <= s_d;
         c_q         <= c_d;
         cnt_q       <= cnt_d;
         result_q    <= result_d;
         iters_q     <= iters_d;
         out_valid_q <= out_valid_d;
         in_ready_q  <= in_ready_d;
      end
   end

   // Next-state and carry-propagation step
   always_comb begin
      state_d  = state_q;
      s_d      = s_q;
      c_d      = c_q;
      cnt_d    = cnt_q;
      result_d = result_q;
      iters_d  = iters_q;

      unique case (state_q)
         ST_IDLE: begin
            if (in_valid) begin
               s_d     = RW'(sum_in);
               c_d     = {1'b0, cout_in, 1'b0};
               cnt_d   = '0;
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            if (c_q == '0) begin
               result_d = s_q;
               iters_d  = cnt_q;
               state_d  = ST_DONE;
            end else if (cnt_q == MAX_ITERS) begin
               // Unreachable for legal inputs; bounds latency regardless
               result_d = s_q;
               iters_d  = cnt_q;
               state_d  = ST_DONE;
            end else begin
               s_d   = s_q ^ c_q;
               c_d   = (s_q & c_q) << 1;
               cnt_d = cnt_q + CW'(1);
            end
         end
         ST_DONE: begin
            if (out_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      out_valid_d = (state_d == ST_DONE);
      in_ready_d  = (state_d == ST_IDLE);
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign result    = result_q;
   assign iters     = iters_q;

   // Carries must drain within WIDTH+2 iterations
   a_guard_unreachable : assert property (
      @(posedge clk) disable iff (!rst_n)
      !((state_q == ST_RUN) && (c_q != '0) && (cnt_q == MAX_ITERS))
   );

endmodule
